ps2_key_rx: RTL and testbench
=============================

Name: ps2_key_rx

Overview:
- Receive-only PS/2 keyboard front end: deserialises device-to-host frames on the PS/2 clock/data lines and assembles Set-2 scan-code sequences.
- Output is the 11-bit toggle-strobe key word consumed by core input decoders: [10] toggles per event, [9] pressed, [8] extended, [7:0] code.
- Sits between the physical or user-port PS/2 pins and any core keyboard mapper; lets a core run without the HPS key path.
- Never drives the PS/2 lines.

Parameters:
- CLK_FILTER, 8: consecutive identical synchronised ps2_clk samples required to change the filtered clock level (range 2..16).
- TIMEOUT, 12000: clk_sys cycles without a filtered falling edge before a partial frame is aborted (1 ms at 12 MHz).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
- ps2_data_in  in  1  raw PS/2 data line, asynchronous.
- ps2_key  out  11  {toggle, pressed, extended, code[7:0]}.
- frame_err  out  1  one-cycle pulse on an aborted or invalid frame.

Behaviour:
- Reset (async assert, sync release): ps2_key=0, frame_err=0, FSM=IDLE, bit count=0, ext/brk flags clear, skip count=0, filtered clock=1, timeout counter=0. Asserting reset mid-frame aborts the frame with no output.
- Inputs: both pass through 2-FF synchronisers. Filtered clock flips only after CLK_FILTER consecutive synchronised samples at the opposite level. Event fall = filtered clock 1->0. Data is sampled from the synchronised data line in the fall cycle.
- Frame FSM, one transition per fall:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay IDLE; no error.
  - DATA: shift the bit in LSB first. After bit 7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop=1 and data^parity has odd parity, the byte is valid. Otherwise pulse frame_err. Either way -> IDLE.
- Timeout: counter clears on every fall and while in IDLE. In any non-IDLE state, when the counter reaches TIMEOUT-1: FSM -> IDLE, frame_err pulses, partial byte is discarded.
- Any frame_err also clears ext, brk and skip count.
- Scan assembler (acts on a valid byte, in the cycle after the STOP fall):
  - skip count != 0: decrement; no output.
  - E1: skip count = 7 (Pause sequence swallowed); clear flags.
  - E0: set ext.
  - F0: set brk.
  - FA, FE, EE, 00, FF: ignored; flags cleared.
  - AA with neither flag set: ignored.
  - Any other byte: ps2_key <= {~ps2_key[10], ~brk, ext, byte}; then clear ext and brk.
- Latency: ps2_key changes exactly 1 cycle after the cycle in which the STOP-bit fall is detected. frame_err is asserted in the same cycle as the corresponding FSM abort/return. At most one ps2_key change per byte.
- ps2_key[9:0] holds its value between events. Consumers detect events only by the change in bit [10].

Test Plan:
- Frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12 kHz PS/2 clock -> ps2_key[10] toggles once, ps2_key[9:0]=10'h21C, 1 cycle after the stop fall; frame_err stays 0.
- Bytes E0, F0, 75 -> a single toggle, after the third byte only; ps2_key[9:0]=10'h175. Then byte 12 -> 10'h212, ext/brk confirmed cleared.
- Byte 0x29 sent with parity=1 (invalid) -> frame_err pulses for 1 cycle; ps2_key unchanged. Next valid 0x29 -> 10'h229.
- Start bit plus 4 data bits, then line idle -> frame_err pulses TIMEOUT cycles after the last fall. A following valid 0x16 frame -> 10'h216.
- Sequence E1 14 77 E1 F0 14 F0 77 -> no change on ps2_key. Then 0x05 -> 10'h205.
- Glitch: ps2_clk low for CLK_FILTER-2 cycles mid-frame -> no bit consumed; the frame still decodes 0x1C -> 10'h21C. Assert reset_n=0 mid-frame -> ps2_key=0 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - receive-only PS/2 keyboard front end producing a toggle-strobe key word
//
// Ports:
//   clk_sys     in   1  system clock, all logic on the rising edge
//   reset_n     in   1  asynchronous active-low reset (released synchronously inside)
//   ps2_clk_in  in   1  raw PS/2 clock line, asynchronous
//   ps2_data_in in   1  raw PS/2 data line, asynchronous
//   ps2_key     out 11  {toggle, pressed, extended, code[7:0]}
//   frame_err   out  1  one-cycle pulse on an aborted or invalid frame

module ps2_key_rx #(
  parameter int CLK_FILTER = 8,
  parameter int TIMEOUT    = 12000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(CLK_FILTER);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    rst_sync_q;
  logic          rst_n_int;
  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          byte_vld_q;
  logic [7:0]    byte_q;
  logic          ext_q;
  logic          brk_q;
  logic [2:0]    skip_q;
  logic [10:0]   key_q;
  logic          err_q;

  logic clk_s, data_s;
  logic fall_d, tmo_hit_d, stop_ok_d, err_d;

  // Assert immediately, release two clocks after reset_n rises.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign clk_s = clk_sync_q[1];
  assign data_s = dat_sync_q[1];

  // The filtered clock is about to go low: the last of CLK_FILTER low samples.
  assign fall_d    = filt_q & ~clk_s & (fcnt_q == FW'(CLK_FILTER - 1));
  assign tmo_hit_d = (state_q != S_IDLE) & ~fall_d & (tmo_q == TW'(TIMEOUT - 1));
  // Data bits plus parity must hold an odd number of ones.
  assign stop_ok_d = data_s & (^{shift_q, par_q});
  assign err_d     = tmo_hit_d | (fall_d & (state_q == S_STOP) & ~stop_ok_d);

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      key_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_data_in};

      if (clk_s != filt_q) begin
        if (fcnt_q == FW'(CLK_FILTER - 1)) begin
          filt_q <= clk_s;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end else begin
        fcnt_q <= '0;
      end

      if (fall_d || state_q == S_IDLE || tmo_hit_d) tmo_q <= '0;
      else                                          tmo_q <= tmo_q + TW'(1);

      err_q      <= err_d;
      byte_vld_q <= 1'b0;

      if (tmo_hit_d) begin
        state_q <= S_IDLE;
      end else if (fall_d) begin
        case (state_q)
          S_IDLE: begin
            if (!data_s) begin
              state_q  <= S_DATA;
              bitcnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q  <= {data_s, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= data_s;
            state_q <= S_STOP;
          end
          default: begin
            state_q <= S_IDLE;
            if (stop_ok_d) begin
              byte_vld_q <= 1'b1;
              byte_q     <= shift_q;
            end
          end
        endcase
      end

      // Scan-code assembler, one cycle behind the stop bit.
      if (err_d) begin
        ext_q  <= 1'b0;
        brk_q  <= 1'b0;
        skip_q <= '0;
      end else if (byte_vld_q) begin
        if (skip_q != 3'd0) begin
          skip_q <= skip_q - 3'd1;
        end else begin
          case (byte_q)
            8'hE1: begin
              // Remaining 7 bytes of the Pause sequence carry no key event.
              skip_q <= 3'd7;
              ext_q  <= 1'b0;
              brk_q  <= 1'b0;
            end
            8'hE0: ext_q <= 1'b1;
            8'hF0: brk_q <= 1'b1;
            8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
            default: begin
              // A bare AA is the self-test pass reply, not a key.
              if (byte_q != 8'hAA || ext_q || brk_q) begin
                key_q <= {~key_q[10], ~brk_q, ext_q, byte_q};
                ext_q <= 1'b0;
                brk_q <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - table-driven scoreboard bench for ps2_key_rx

module tb_ps2_key_rx;

  localparam int CLK_FILTER = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HP         = 40;

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        ps2_clk_in  = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_rx #(.CLK_FILTER(CLK_FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] b;
    logic       bad;
    logic       tog;
    logic [9:0] val;
    logic       err;
  } vec_t;

  vec_t       tbl[$];
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = 0;
  int n_tog = 0;
  int n_err = 0;
  int err_w = 0;
  logic last_tog = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    n_vec++;
    if (got < lo || got > hi) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Scoreboard: every toggle of bit 10 pops one expected key word.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      last_tog = 1'b0;
      err_w    = 0;
    end else begin
      if (ps2_key[10] !== last_tog) begin
        last_tog = ps2_key[10];
        n_tog++;
        if (exp_q.size() == 0) begin
          chk("unexpected_toggle", 1, 0);
        end else begin
          chk("key_value", ps2_key[9:0], exp_q.pop_front());
          chk_rng("key_latency", cyc - last_fall_cyc, CLK_FILTER + 1, CLK_FILTER + 6);
        end
      end
      if (frame_err) begin
        if (err_w == 0) begin
          n_err++;
          last_err_cyc = cyc;
        end
        err_w++;
      end else if (err_w != 0) begin
        chk("err_width", err_w, 1);
        err_w = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data_in = b;
    if (glitch) begin
      wait_cyc(4);
      ps2_clk_in = 1'b0;
      wait_cyc(CLK_FILTER - 2);
      ps2_clk_in = 1'b1;
      wait_cyc(HP / 2 - 4 - (CLK_FILTER - 2));
    end else begin
      wait_cyc(HP / 2);
    end
    ps2_clk_in    = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HP);
    ps2_clk_in = 1'b1;
    wait_cyc(HP / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad, input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
    ps2_data_in = 1'b1;
  endtask

  task automatic add(input logic [7:0] b, input logic bad, input logic tog, input logic [9:0] val, input logic err);
    vec_t v;
    v.b = b; v.bad = bad; v.tog = tog; v.val = val; v.err = err;
    tbl.push_back(v);
  endtask

  // One full frame with expectations on toggle count, error count and value.
  task automatic run_frame(input string name, input logic [7:0] b, input logic bad, input int glitch_at,
                           input logic tog, input logic [9:0] val, input logic err);
    int t0, e0;
    t0 = n_tog;
    e0 = n_err;
    if (tog) exp_q.push_back(val);
    send_frame(b, bad, 11, glitch_at);
    wait_cyc(20);
    chk({name, "_toggles"}, n_tog - t0, int'(tog));
    chk({name, "_errors"}, n_err - e0, int'(err));
    if (err) chk_rng({name, "_err_latency"}, last_err_cyc - last_fall_cyc, CLK_FILTER, CLK_FILTER + 6);
    if (tog) chk({name, "_key"}, ps2_key[9:0], val);
  endtask

  initial begin
    int e0, t0;

    add(8'h1C, 0, 1, 10'h21C, 0);
    add(8'hE0, 0, 0, 10'h000, 0);
    add(8'hF0, 0, 0, 10'h000, 0);
    add(8'h75, 0, 1, 10'h175, 0);
    add(8'h12, 0, 1, 10'h212, 0);
    add(8'h29, 1, 0, 10'h000, 1);
    add(8'h29, 0, 1, 10'h229, 0);
    add(8'hE1, 0, 0, 10'h000, 0);
    add(8'h14, 0, 0, 10'h000, 0);
    add(8'h77, 0, 0, 10'h000, 0);
    add(8'hE1, 0, 0, 10'h000, 0);
    add(8'hF0, 0, 0, 10'h000, 0);
    add(8'h14, 0, 0, 10'h000, 0);
    add(8'hF0, 0, 0, 10'h000, 0);
    add(8'h77, 0, 0, 10'h000, 0);
    add(8'h05, 0, 1, 10'h205, 0);
    add(8'hAA, 0, 0, 10'h000, 0);
    add(8'hE0, 0, 0, 10'h000, 0);
    add(8'hAA, 0, 1, 10'h3AA, 0);
    add(8'hE0, 0, 0, 10'h000, 0);
    add(8'hFA, 0, 0, 10'h000, 0);
    add(8'h1C, 0, 1, 10'h21C, 0);
    add(8'hFF, 0, 0, 10'h000, 0);
    add(8'hEE, 0, 0, 10'h000, 0);
    add(8'hFE, 0, 0, 10'h000, 0);
    add(8'h00, 0, 0, 10'h000, 0);
    add(8'hF0, 0, 0, 10'h000, 0);
    add(8'h1C, 0, 1, 10'h01C, 0);

    wait_cyc(5);
    #1;
    chk("reset_key", ps2_key, 0);
    chk("reset_err", frame_err, 0);
    reset_n = 1'b1;
    wait_cyc(10);

    for (int i = 0; i < tbl.size(); i++)
      run_frame($sformatf("row%0d", i), tbl[i].b, tbl[i].bad, -1, tbl[i].tog, tbl[i].val, tbl[i].err);

    // Partial frame then silence: the receiver must give up on its own.
    e0 = n_err;
    t0 = n_tog;
    send_frame(8'h3C, 0, 5, -1);
    wait_cyc(TIMEOUT + 60);
    chk("timeout_errors", n_err - e0, 1);
    chk("timeout_toggles", n_tog - t0, 0);
    chk_rng("timeout_latency", last_err_cyc - last_fall_cyc, TIMEOUT, TIMEOUT + 15);
    run_frame("after_timeout", 8'h16, 0, -1, 1, 10'h216, 0);

    run_frame("glitch", 8'h1C, 0, 5, 1, 10'h21C, 0);

    // Reset in the middle of a frame clears the key word at once.
    e0 = n_err;
    send_frame(8'h4B, 0, 4, -1);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("midreset_key", ps2_key, 0);
    chk("midreset_err", frame_err, 0);
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(10);
    chk("midreset_no_err", n_err - e0, 0);
    run_frame("after_reset", 8'h1C, 0, -1, 1, 10'h21C, 0);

    wait_cyc(20);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
